// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock.
// The carry ripples through a register between chunks. Valid/ready handshakes
// sit on both sides, and the result is held in DONE until the consumer takes it.

// One chunk slice: CHUNK-bit add with carry in and carry out.
module chunked_adder_cell #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;   // b_q holds b_eff (inverted for subtract)
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] cs;
  logic             co;
  logic             last;

  assign last = (cnt == CW'(NCHUNK - 1));

  // Adder for the chunk currently selected by the counter.
  chunked_adder_cell #(.CHUNK(CHUNK)) u_cell (
    .a  (a_q[cnt*CHUNK +: CHUNK]),
    .b  (b_q[cnt*CHUNK +: CHUNK]),
    .ci (carry),
    .s  (cs),
    .co (co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture operands at handshake, then one chunk per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= sub ? ~b : b;
          carry <= sub ? 1'b1 : cin;
          cnt   <= '0;
        end
        RUN: begin
          sum[cnt*CHUNK +: CHUNK] <= cs;
          carry <= co;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum[WIDTH] <= co;
            // Overflow: operands share a sign that the result does not.
            ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cs[CHUNK-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder (WIDTH=16, CHUNK=4).
module tb_chunked_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] sum;
  logic        ovf;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands while idle and complete the input handshake.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic sv);
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~av; b = ~bv; cin = ~cv; sub = ~sv;  // must not affect the result
  endtask

  // Wait (bounded) for out_valid; returns edges elapsed since the handshake.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Full operation with out_ready high: latency, result, then release.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic sv,
                        input logic [16:0] es, input logic eo);
    int n;
    out_ready = 1'b1;
    chk({tag, ".in_ready"}, in_ready, 1);
    start_op(av, bv, cv, sv);
    wait_done(n);
    chk({tag, ".latency"}, n, 4);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".ovf"}, ovf, eo);
    @(posedge clk); #1;
    chk({tag, ".released"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int n, t1, t2;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.sum", sum, 0);
    chk("rst.ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op("zero",   16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0);
    run_op("cin",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000, 1'b0);
    run_op("sub5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0);
    run_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1);
    run_op("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1);
    // cin must be ignored in subtract mode
    run_op("subcin", 16'h0010, 16'h0003, 1'b1, 1'b1, 17'h1000D, 1'b0);

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    start_op(16'h9234, 16'h8111, 1'b0, 1'b0);
    wait_done(n);
    chk("bp.latency", n, 4);
    for (int i = 0; i < 5; i++) begin
      a = 16'(i * 16'h1357); b = ~a; in_valid = i[0];
      @(posedge clk); #1;
      chk("bp.out_valid", out_valid, 1);
      chk("bp.in_ready", in_ready, 0);
      chk("bp.sum", sum, 17'h11345);
      chk("bp.ovf", ovf, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release", {out_valid, in_ready}, 2'b01);

    // Reset during the second RUN cycle aborts the operation.
    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst.out_valid", out_valid, 0);
    chk("arst.in_ready", in_ready, 1);
    chk("arst.sum", sum, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("arst.no_result", out_valid, 0);
    run_op("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 17'h02345, 1'b0);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'hF0F1;
    wait_done(n);
    t1 = cyc;
    chk("b2b.first_lat", n, 4);
    chk("b2b.first_sum", sum, 17'h00100);
    @(posedge clk); #1;   // result consumed
    @(posedge clk); #1;   // second handshake
    in_valid = 1'b0;
    wait_done(n);
    t2 = cyc;
    chk("b2b.second_sum", sum, 17'h10000);
    chk("b2b.second_ovf", ovf, 0);
    chk("b2b.spacing", t2 - t1, 6);
    @(posedge clk); #1;
    chk("b2b.idle", {out_valid, in_ready}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register between chunks.
- Has a valid/ready handshake on both input and output, a carry-in, a subtract mode and a signed-overflow flag.
- Sits in the datapath wherever a wide add must meet timing at the cost of latency.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  1 selects a-b, 0 selects a+b+cin.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH+1  result; bit WIDTH is carry-out (add) or no-borrow (sub).
- ovf  output  1  signed two's-complement overflow of the WIDTH-bit result.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: in_ready=1, out_valid=0, sum=0, ovf=0, state=IDLE, chunk counter=0, carry register=0.
- A rst assertion mid-operation aborts it immediately; the result is discarded, and no out_valid is produced for it.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b_eff and the initial carry; go to RUN with counter=0.
  - Subtract (sub=1): b_eff = ~b and initial carry = 1. cin is ignored.
  - Add (sub=0): b_eff = b and initial carry = cin.
  - RUN: in_ready=0. Each cycle adds chunk[counter] of a, chunk[counter] of b_eff and the carry register (CHUNK+1-bit add).
  - RUN writes the low CHUNK bits into sum[counter*CHUNK +: CHUNK] and the carry-out into the carry register. Counter increments.
  - On the cycle processing chunk NCHUNK-1, RUN also writes sum[WIDTH] = final carry and computes ovf, then goes to DONE.
  - ovf = (a[WIDTH-1]==b_eff[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]).
  - DONE: out_valid=1, in_ready=0. sum and ovf are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready, DONE goes to IDLE and out_valid drops the next cycle.
- Latency and throughput:
  - If the input handshake occurs at rising edge k, out_valid is first high after edge k+NCHUNK.
  - Throughput is one operation per NCHUNK+2 cycles with out_ready held high.
- Operands and mode are captured only at the input handshake. Changes on a, b, cin or sub during RUN or DONE have no effect.
- in_valid while in_ready=0 is ignored; the source must hold its data until the handshake.
- sum bits not yet written in RUN keep their previous values. Only the DONE value is defined.
- CHUNK=WIDTH is the degenerate case: one RUN cycle, latency 1.
- Wrap-around: the add is modulo 2^WIDTH in sum[WIDTH-1:0], and the carry/no-borrow always appears in sum[WIDTH].

Test Plan (defaults WIDTH=16, CHUNK=4):
- Zero add: a=0x0000, b=0x0000, cin=0, sub=0 -> after 4 cycles out_valid=1, sum=0x00000, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x10000, ovf=0. Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x10000.
- Subtract and signed overflow:
  - sub=1, a=0x0005, b=0x0007 -> sum=0x0FFFE (bit16=0, borrow), ovf=0.
  - sub=0, a=0x7FFF, b=0x0001 -> sum=0x08000, ovf=1.
  - sub=1, a=0x8000, b=0x0001 -> sum=0x17FFF, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, while toggling a/b/in_valid.
  - Required: sum, ovf and out_valid stay stable and in_ready=0.
  - Then raise out_ready for 1 cycle: out_valid falls and in_ready=1.
- Reset mid-operation: assert rst for 1 cycle during the second RUN cycle.
  - Required: out_valid=0, in_ready=1 and sum=0 immediately (asynchronous).
  - A following a=0x1234 + b=0x1111 must give sum=0x02345.
- Back-to-back with out_ready tied high: 0x00FF+0x0001 then 0x0F0F+0xF0F1.
  - Required: results 0x00100 and 0x10000, with out_valid rises 6 cycles apart.
